clk_div_bank: RTL and testbench

Multi-channel, run-time programmable tick/square-wave generator: the next-generation replacement for the fixed single-output slow clock divider. It produces clock-enable pulses and divided level signals for N_CH independent channels from the single fabric clock. No derived clock is routed onto a global buffer; all consumers stay on clk and qualify logic with tick. A valid/ready config port retunes any channel without glitching its output.

---
 rtl/clk_div_bank_pkg.sv | 21 ++
 rtl/clk_div_chan.sv | 100 ++++++++++
 rtl/clk_div_bank.sv | 66 ++++++
 tb/tb_clk_div_bank.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_bank_pkg.sv
// Shared types and elaboration helpers for the programmable tick/level bank.
// Sizes the channel-select field and derives the reset divisor from the clock and default frequency.
package clk_div_bank_pkg;

   localparam int CFG_W_DIV = 32;

   typedef struct packed {
      logic [CFG_W_DIV-1:0] div;
      logic                 en;
   } chan_cfg_t;

   // Half period of the default output frequency, in fabric clock cycles.
   function automatic longint def_div(input longint mhz, input longint hz);
      return (mhz * 1000000) / hz / 2;
   endfunction

   function automatic int ch_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: a down-counter with tick/level registers and a shadow config.
// The shadow config is committed only on a wrap edge, so every output period is either entirely old or entirely new.
module clk_div_chan
   import clk_div_bank_pkg::*;
#(
   parameter int               W_DIV   = 32,
   parameter logic [W_DIV-1:0] DEF_DIV = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_restart,
   input  logic             i_cfgWr,
   input  logic [W_DIV-1:0] i_cfgDiv,
   input  logic             i_cfgEn,
   output logic             o_tick,
   output logic             o_level,
   output logic             o_pending
);

   logic [W_DIV-1:0] r_div;
   logic             r_en;
   logic [W_DIV-1:0] r_shadowDiv;
   logic             r_shadowEn;
   logic             r_pending;
   logic [W_DIV-1:0] r_cnt;
   logic             r_tick;
   logic             r_level;

   logic             w_wrap;
   logic             w_bypass;
   logic [W_DIV-1:0] w_newDiv;
   logic             w_newEn;
   logic [W_DIV-1:0] w_newCnt;

   // A write can land immediately when no period is in flight; otherwise it waits in the shadow.
   always_comb begin
      w_wrap   = r_en && (r_cnt == '0);
      w_bypass = i_cfgWr && (!r_en || (r_cnt == '0));
      w_newDiv = r_div;
      w_newEn  = r_en;
      if (i_cfgWr && (i_restart || w_bypass)) begin
         w_newDiv = i_cfgDiv;
         w_newEn  = i_cfgEn;
      end else if (r_pending && (i_restart || w_wrap)) begin
         w_newDiv = r_shadowDiv;
         w_newEn  = r_shadowEn;
      end
      w_newCnt = w_newDiv - W_DIV'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_div       <= DEF_DIV;
         r_en        <= 1'b1;
         r_shadowDiv <= DEF_DIV;
         r_shadowEn  <= 1'b1;
         r_pending   <= 1'b0;
         r_cnt       <= DEF_DIV - W_DIV'(1);
         r_tick      <= 1'b0;
         r_level     <= 1'b0;
      end else if (i_restart) begin
         r_div     <= w_newDiv;
         r_en      <= w_newEn;
         r_pending <= 1'b0;
         r_cnt     <= w_newCnt;
         r_tick    <= 1'b0;
         r_level   <= 1'b0;
      end else begin
         r_div <= w_newDiv;
         r_en  <= w_newEn;
         if (i_cfgWr && !w_bypass) begin
            r_shadowDiv <= i_cfgDiv;
            r_shadowEn  <= i_cfgEn;
            r_pending   <= 1'b1;
         end else if (w_wrap) begin
            r_pending <= 1'b0;
         end
         if (!w_newEn) begin
            r_cnt   <= w_newCnt;
            r_tick  <= 1'b0;
            r_level <= 1'b0;
         end else if (w_wrap) begin
            r_cnt   <= w_newCnt;
            r_tick  <= 1'b1;
            r_level <= ~r_level;
         end else if (!r_en) begin
            r_cnt  <= w_newCnt;
            r_tick <= 1'b0;
         end else begin
            r_cnt  <= r_cnt - W_DIV'(1);
            r_tick <= 1'b0;
         end
      end
   end

   assign o_tick    = r_tick;
   assign o_level   = r_level;
   assign o_pending = r_pending;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of run-time programmable tick/level generators, all running on the fabric clock.
// Holds the config decode and the ready mux; each channel keeps its own counter and shadow config.
module clk_div_bank
   import clk_div_bank_pkg::*;
#(
   parameter int  FAST_CLK_MHZ = 50,
   parameter int  DEFAULT_HZ   = 3,
   parameter int  N_CH         = 4,
   parameter int  W_DIV        = 32,
   localparam int W_CH         = ch_width(N_CH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [W_CH-1:0]  cfg_ch,
   input  logic [W_DIV-1:0] cfg_div,
   input  logic             cfg_en,
   input  logic             restart,
   output logic [N_CH-1:0]  tick,
   output logic [N_CH-1:0]  level
);

   localparam longint           DEF_DIV_L = def_div(FAST_CLK_MHZ, DEFAULT_HZ);
   localparam logic [W_DIV-1:0] DEF_DIV   = W_DIV'(DEF_DIV_L);

   if (DEF_DIV_L < 1 || DEF_DIV_L >= (longint'(1) << W_DIV)) begin : g_badDefDiv
      $error("clk_div_bank: default divisor does not fit in W_DIV");
   end
   if (N_CH < 1 || N_CH > 16) begin : g_badNch
      $error("clk_div_bank: N_CH must be 1..16");
   end

   logic [N_CH-1:0]        w_pending;
   logic [(2**W_CH)-1:0]   w_pendPad;
   logic [W_DIV-1:0]       w_cfgDiv;
   logic                   w_cfgAccept;

   // Unused select codes read as not-pending, so writes to them are accepted and dropped.
   always_comb begin
      w_pendPad            = '0;
      w_pendPad[N_CH-1:0]  = w_pending;
   end

   assign cfg_ready   = !w_pendPad[cfg_ch];
   assign w_cfgAccept = cfg_valid && cfg_ready;
   assign w_cfgDiv    = (cfg_div == '0) ? W_DIV'(1) : cfg_div;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      clk_div_chan #(
         .W_DIV   (W_DIV),
         .DEF_DIV (DEF_DIV)
      ) u_chan (
         .i_clk     (clk),
         .i_rst     (rst),
         .i_restart (restart),
         .i_cfgWr   (w_cfgAccept && (cfg_ch == W_CH'(i))),
         .i_cfgDiv  (w_cfgDiv),
         .i_cfgEn   (cfg_en),
         .o_tick    (tick[i]),
         .o_level   (level[i]),
         .o_pending (w_pending[i])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with a 5-cycle default divisor and three channels.
// k counts clock edges since the end of reset; every expected value below is written in terms of k.
module tb_clk_div_bank;

   localparam int N_CH  = 3;
   localparam int W_DIV = 32;
   localparam int W_CH  = 2;

   logic             clk;
   logic             rst;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [W_CH-1:0]  cfg_ch;
   logic [W_DIV-1:0] cfg_div;
   logic             cfg_en;
   logic             restart;
   logic [N_CH-1:0]  tick;
   logic [N_CH-1:0]  level;

   int checks = 0;
   int errors = 0;
   int k      = 0;

   logic [N_CH-1:0] expTick;
   logic [N_CH-1:0] expLevel;
   logic            expReady;

   clk_div_bank #(
      .FAST_CLK_MHZ (1),
      .DEFAULT_HZ   (100000),
      .N_CH         (N_CH),
      .W_DIV        (W_DIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_en    (cfg_en),
      .restart   (restart),
      .tick      (tick),
      .level     (level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic test_reset();
      rst = 1'b1; restart = 1'b0; cfg_valid = 1'b0;
      cfg_ch = '0; cfg_div = '0; cfg_en = 1'b1;
      step(); step();
      rst = 1'b0;
      k = 0;
      checks++;
      if (tick !== 3'b000 || level !== 3'b000 || cfg_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_state: tick=%b level=%b ready=%b, required 000 000 1", tick, level, cfg_ready);
      end
      repeat (10) begin
         step();
         expTick  = (k % 5 == 0) ? 3'b111 : 3'b000;
         expLevel = ((k / 5) % 2 == 1) ? 3'b111 : 3'b000;
         checks++;
         if (tick !== expTick || level !== expLevel) begin
            errors++;
            $display("[TB] FAIL default_div k=%0d: tick=%b level=%b, required %b %b", k, tick, level, expTick, expLevel);
         end
      end
   endtask

   task automatic test_retune();
      cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd3; cfg_en = 1'b1;
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL retune_ready_idle: ready=%b, required 1", cfg_ready);
      end
      repeat (11) begin
         step();
         cfg_valid = 1'b0;
         expTick[0] = (k % 5 == 0);
         expTick[2] = (k % 5 == 0);
         expTick[1] = (k <= 15) ? (k % 5 == 0) : ((k - 15) % 3 == 0);
         expReady   = !(k >= 11 && k <= 14);
         checks++;
         if (tick !== expTick || cfg_ready !== expReady) begin
            errors++;
            $display("[TB] FAIL retune k=%0d: tick=%b ready=%b, required %b %b", k, tick, cfg_ready, expTick, expReady);
         end
      end
      checks++;
      if (level !== 3'b010) begin
         errors++;
         $display("[TB] FAIL retune_level: level=%b, required 010", level);
      end
   endtask

   task automatic test_div_zero();
      cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 32'd0; cfg_en = 1'b1;
      repeat (9) begin
         step();
         cfg_valid = 1'b0;
         expTick[0] = (k % 5 == 0);
         expTick[1] = ((k - 15) % 3 == 0);
         expTick[2] = (k >= 25);
         expLevel[2] = (k >= 25) ? ((k - 25) % 2 == 0) : 1'b0;
         checks++;
         if (tick !== expTick || level[2] !== expLevel[2]) begin
            errors++;
            $display("[TB] FAIL div_zero k=%0d: tick=%b level2=%b, required %b %b", k, tick, level[2], expTick, expLevel[2]);
         end
      end
   endtask

   task automatic test_disable_restart();
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 32'd5; cfg_en = 1'b0;
      repeat (10) begin
         step();
         cfg_valid = 1'b0;
         expTick[0] = 1'b0;
         expTick[1] = ((k - 15) % 3 == 0);
         expTick[2] = 1'b1;
         expReady   = (k >= 35);
         checks++;
         if (tick !== expTick || cfg_ready !== expReady || level[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL disable k=%0d: tick=%b ready=%b level0=%b, required %b %b 0", k, tick, cfg_ready, level[0], expTick, expReady);
         end
      end
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 32'd4; cfg_en = 1'b1; restart = 1'b1;
      step();
      cfg_valid = 1'b0; restart = 1'b0;
      checks++;
      if (tick !== 3'b000 || level !== 3'b000) begin
         errors++;
         $display("[TB] FAIL restart_edge: tick=%b level=%b, required 000 000", tick, level);
      end
      repeat (8) begin
         step();
         expTick[0]  = ((k - 41) % 4 == 0);
         expTick[1]  = ((k - 41) % 3 == 0);
         expTick[2]  = 1'b1;
         expLevel[0] = (((k - 41) / 4) % 2 == 1);
         expLevel[1] = (((k - 41) / 3) % 2 == 1);
         expLevel[2] = ((k - 41) % 2 == 1);
         checks++;
         if (tick !== expTick || level !== expLevel) begin
            errors++;
            $display("[TB] FAIL restart_align k=%0d: tick=%b level=%b, required %b %b", k, tick, level, expTick, expLevel);
         end
      end
   endtask

   task automatic test_out_of_range();
      cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 32'd2; cfg_en = 1'b0;
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL oor_ready: ready=%b, required 1", cfg_ready);
      end
      repeat (8) begin
         step();
         cfg_valid = 1'b0;
         expTick[0] = ((k - 41) % 4 == 0);
         expTick[1] = ((k - 41) % 3 == 0);
         expTick[2] = 1'b1;
         checks++;
         if (tick !== expTick || cfg_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL oor_ignored k=%0d: tick=%b ready=%b, required %b 1", k, tick, cfg_ready, expTick);
         end
      end
   endtask

   task automatic test_reset_mid_pending();
      cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd7; cfg_en = 1'b1;
      step();
      cfg_valid = 1'b0;
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL pending_before_rst: ready=%b, required 0", cfg_ready);
      end
      rst = 1'b1; restart = 1'b1;
      step();
      rst = 1'b0; restart = 1'b0;
      checks++;
      if (tick !== 3'b000 || level !== 3'b000 || cfg_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rst_mid_pending: tick=%b level=%b ready=%b, required 000 000 1", tick, level, cfg_ready);
      end
      repeat (10) begin
         step();
         expTick  = ((k - 59) % 5 == 0) ? 3'b111 : 3'b000;
         expLevel = (((k - 59) / 5) % 2 == 1) ? 3'b111 : 3'b000;
         checks++;
         if (tick !== expTick || level !== expLevel) begin
            errors++;
            $display("[TB] FAIL post_rst_div k=%0d: tick=%b level=%b, required %b %b", k, tick, level, expTick, expLevel);
         end
      end
   endtask

   initial begin
      test_reset();
      test_retune();
      test_div_zero();
      test_disable_restart();
      test_out_of_range();
      test_reset_mid_pending();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
